if_id_latch: RTL and testbench

- IF/ID pipeline register directly downstream of the program counter and instruction memory.
- Captures each fetched instruction and its next-PC, and presents them to the decode stage.
- A 2-entry skid buffer decouples fetch from decode: hazard-unit stalls never drop an instruction.
- Branch/jump flush squashes all buffered fetches to NOP bubbles.

---
 rtl/if_id_latch_pkg.sv | 15 +
 rtl/if_id_latch_entry.sv | 32 +++
 rtl/if_id_latch.sv | 140 ++++++++++++++
 tb/tb_if_id_latch.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/if_id_latch_pkg.sv
// Shared types and defaults for the IF/ID pipeline latch.
// IF_ID_PERF_EN (in the top) adds stall and squash performance counters.
package if_id_latch_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned PERF_W     = 32;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/if_id_latch_entry.sv
// One buffered fetch: valid + instruction + next-PC, cleared to a NOP bubble.
module if_id_entry
  import if_id_latch_pkg::*;
#(
  parameter int unsigned       DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(DEF_NOP_INSTR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_instr,
  input  logic [DATA_W-1:0] d_npc,
  output logic              valid,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] npc
);

  // Clear wins over load so an invalid entry never carries stale fields.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      npc   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= d_instr;
      npc   <= d_npc;
    end
  end

endmodule

// File: rtl/if_id_latch.sv
// IF/ID pipeline register with a 2-entry skid buffer and branch flush.
// Define IF_ID_PERF_EN to add stall_cycles / squash_count counters.
module if_id_latch
  import if_id_latch_pkg::*;
#(
  parameter int unsigned       DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(DEF_NOP_INSTR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_npc,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0] out_npc
`ifdef IF_ID_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] squash_count
`endif
);

  state_t            state, state_next;
  logic              accept, consume;
  logic              main_load, main_clear, main_from_skid;
  logic              skid_load, skid_clear;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_instr, skid_npc;
  logic [DATA_W-1:0] main_d_instr, main_d_npc;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & ~stall;

  // Entry control and next state; flush squashes everything, including this cycle's accept.
  always_comb begin
    state_next     = state;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_next = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_load  = 1'b1;
            state_next = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_load = 1'b1;
          end else if (accept) begin
            skid_load  = 1'b1;
            state_next = FULL;
          end else if (consume) begin
            main_clear = 1'b1;
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_next     = ONE;
          end
        end
        default: begin
          state_next = EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign main_d_instr = main_from_skid ? skid_instr : in_instr;
  assign main_d_npc   = main_from_skid ? skid_npc   : in_npc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != FULL);
    end
  end

  if_id_entry #(.DATA_W(DATA_W), .NOP_INSTR(NOP_INSTR)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load    (main_load),
    .clear   (main_clear),
    .d_instr (main_d_instr),
    .d_npc   (main_d_npc),
    .valid   (out_valid),
    .instr   (out_instr),
    .npc     (out_npc)
  );

  if_id_entry #(.DATA_W(DATA_W), .NOP_INSTR(NOP_INSTR)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .clear   (skid_clear),
    .d_instr (in_instr),
    .d_npc   (in_npc),
    .valid   (skid_valid),
    .instr   (skid_instr),
    .npc     (skid_npc)
  );

`ifdef IF_ID_PERF_EN
  // Counters wrap naturally; squash counts live entries at the flush edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      squash_count <= '0;
    end else begin
      if (out_valid && stall) begin
        stall_cycles <= stall_cycles + PERF_W'(1);
      end
      if (flush) begin
        squash_count <= squash_count + PERF_W'(out_valid) + PERF_W'(skid_valid);
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_id_latch.sv
// Self-checking bench for if_id_latch: directed vector table plus a random queue-model run.
module tb_if_id_latch;

  localparam logic [31:0] INS_A = 32'h2008_0005;
  localparam logic [31:0] INS_B = 32'h2009_0003;
  localparam logic [31:0] INS_C = 32'h214A_0001;
  localparam int NVEC = 24;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, stall, flush, out_valid;
  logic [31:0] in_instr, in_npc, out_instr, out_npc;
`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cycles, squash_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_id_latch dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_npc    (in_npc),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_npc   (out_npc)
`ifdef IF_ID_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .squash_count (squash_count)
`endif
  );

  typedef struct {
    logic        rst, iv;
    logic [31:0] instr, npc;
    logic        stall, flush;
    logic        ev;
    logic [31:0] ei, en;
    logic        er;
    logic [31:0] esc, esq;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic r, input logic iv, input logic [31:0] ins,
                              input logic [31:0] npc, input logic st, input logic fl,
                              input logic ev, input logic [31:0] ei, input logic [31:0] en,
                              input logic er, input logic [31:0] esc, input logic [31:0] esq);
    vec_t v;
    v.rst = r; v.iv = iv; v.instr = ins; v.npc = npc; v.stall = st; v.flush = fl;
    v.ev = ev; v.ei = ei; v.en = en; v.er = er; v.esc = esc; v.esq = esq;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [31:0] ins,
                       input logic [31:0] npc, input logic st, input logic fl);
    rst = r; in_valid = iv; in_instr = ins; in_npc = npc; stall = st; flush = fl;
  endtask

  logic [63:0] q[$];
  int unsigned m_stall, m_squash;
  logic [31:0] seq;

  initial begin
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    //         rst iv instr  npc     st fl   ev ei     en     er esc esq
    vecs[0]  = mk(1, 0, 32'h0, 32'd0,  0, 0,  0, 32'h0, 32'd0, 1, 0, 0);
    vecs[1]  = mk(0, 0, 32'h0, 32'd0,  0, 0,  0, 32'h0, 32'd0, 1, 0, 0);
    vecs[2]  = mk(0, 0, 32'h0, 32'd0,  0, 0,  0, 32'h0, 32'd0, 1, 0, 0);
    vecs[3]  = mk(0, 0, 32'h0, 32'd0,  0, 0,  0, 32'h0, 32'd0, 1, 0, 0);
    vecs[4]  = mk(0, 0, 32'h0, 32'd0,  0, 0,  0, 32'h0, 32'd0, 1, 0, 0);
    vecs[5]  = mk(0, 0, 32'h0, 32'd0,  0, 0,  0, 32'h0, 32'd0, 1, 0, 0);
    vecs[6]  = mk(0, 1, INS_A, 32'd4,  0, 0,  1, INS_A, 32'd4, 1, 0, 0);
    vecs[7]  = mk(0, 1, INS_B, 32'd8,  0, 0,  1, INS_B, 32'd8, 1, 0, 0);
    vecs[8]  = mk(0, 0, 32'h0, 32'd0,  0, 0,  0, 32'h0, 32'd0, 1, 0, 0);
    vecs[9]  = mk(0, 1, INS_A, 32'd4,  1, 0,  1, INS_A, 32'd4, 1, 0, 0);
    vecs[10] = mk(0, 1, INS_B, 32'd8,  1, 0,  1, INS_A, 32'd4, 0, 1, 0);
    vecs[11] = mk(0, 1, INS_C, 32'd12, 1, 0,  1, INS_A, 32'd4, 0, 2, 0);
    vecs[12] = mk(0, 0, 32'h0, 32'd0,  0, 0,  1, INS_B, 32'd8, 1, 2, 0);
    vecs[13] = mk(0, 0, 32'h0, 32'd0,  0, 0,  0, 32'h0, 32'd0, 1, 2, 0);
    vecs[14] = mk(0, 1, INS_A, 32'd4,  1, 0,  1, INS_A, 32'd4, 1, 2, 0);
    vecs[15] = mk(0, 1, INS_B, 32'd8,  1, 0,  1, INS_A, 32'd4, 0, 3, 0);
    vecs[16] = mk(0, 1, INS_C, 32'd12, 1, 1,  0, 32'h0, 32'd0, 1, 4, 2);
    vecs[17] = mk(0, 0, 32'h0, 32'd0,  0, 0,  0, 32'h0, 32'd0, 1, 4, 2);
    vecs[18] = mk(0, 1, INS_A, 32'd4,  0, 0,  1, INS_A, 32'd4, 1, 4, 2);
    vecs[19] = mk(0, 1, INS_C, 32'd12, 0, 1,  0, 32'h0, 32'd0, 1, 4, 3);
    vecs[20] = mk(0, 0, 32'h0, 32'd0,  1, 0,  0, 32'h0, 32'd0, 1, 4, 3);
    vecs[21] = mk(0, 1, INS_A, 32'd4,  0, 0,  1, INS_A, 32'd4, 1, 4, 3);
    vecs[22] = mk(1, 1, INS_C, 32'd12, 0, 1,  0, 32'h0, 32'd0, 1, 0, 0);
    vecs[23] = mk(0, 0, 32'h0, 32'd0,  0, 0,  0, 32'h0, 32'd0, 1, 0, 0);

    // Directed table: inputs before an edge, expected outputs just after it.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].instr, vecs[i].npc, vecs[i].stall, vecs[i].flush);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      chk($sformatf("v%0d out_instr", i), out_instr, vecs[i].ei);
      chk($sformatf("v%0d out_npc", i), out_npc, vecs[i].en);
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].er));
`ifdef IF_ID_PERF_EN
      chk($sformatf("v%0d stall_cycles", i), stall_cycles, vecs[i].esc);
      chk($sformatf("v%0d squash_count", i), squash_count, vecs[i].esq);
`endif
    end

    // Random traffic against a queue model; the DUT was left empty and out of reset.
    q.delete();
    m_stall  = 0;
    m_squash = 0;
    seq      = 32'h1000;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic r, iv, st, fl, acc, con;
      logic [63:0] head;
      head = (q.size() > 0) ? q[0] : 64'h0;
      chk("rnd out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("rnd out_instr", out_instr, head[63:32]);
      chk("rnd out_npc", out_npc, head[31:0]);
      chk("rnd in_ready", 32'(in_ready), 32'(q.size() < 2));
`ifdef IF_ID_PERF_EN
      chk("rnd stall_cycles", stall_cycles, m_stall);
      chk("rnd squash_count", squash_count, m_squash);
`endif
      r  = ($urandom_range(0, 199) == 0);
      fl = ($urandom_range(0, 19) == 0);
      iv = ($urandom_range(0, 9) < 6);
      st = ($urandom_range(0, 9) < 4);
      seq = seq + 32'd1;
      drive(r, iv, seq, seq << 2, st, fl);
      acc = iv && (q.size() < 2);
      con = (q.size() > 0) && !st;
      if (r) begin
        q.delete();
        m_stall  = 0;
        m_squash = 0;
      end else begin
        if ((q.size() > 0) && st) m_stall++;
        if (fl) begin
          m_squash += q.size();
          q.delete();
        end else begin
          if (con) void'(q.pop_front());
          if (acc) q.push_back({seq, seq << 2});
        end
      end
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
